gray_step_decoder: RTL and testbench

//  Receive side of the 3-bit Gray count bus driven by the gray counter. Samples gray_in,

---
 rtl/gray_step_pkg.sv | 27 ++
 rtl/gray_step_sync.sv | 23 ++
 rtl/gray_step_decoder.sv | 117 +++++++++++
 tb/tb_gray_step_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_step_pkg.sv
// Shared types, default widths and Gray decode helper for the Gray step decoder.
package gray_step_pkg;

  localparam int unsigned GS_WIDTH = 3;
  localparam int unsigned GS_POS_W = 8;
  localparam int unsigned GS_MAX_W = 16;

  localparam logic [GS_MAX_W-1:0] DELTA_UP = GS_MAX_W'(1);
  localparam logic [GS_MAX_W-1:0] DELTA_DN = '1;

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } gs_state_e;

  // Zero-extended inputs decode correctly because leading zeros propagate as zeros.
  function automatic logic [GS_MAX_W-1:0] gray2bin(input logic [GS_MAX_W-1:0] g);
    logic [GS_MAX_W-1:0] b;
    b[GS_MAX_W-1] = g[GS_MAX_W-1];
    for (int i = int'(GS_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step_sync.sv
// WIDTH-bit two-flop synchronizer for an asynchronous Gray source.
module gray_step_sync #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Gray count bus receiver: decodes, classifies steps, tracks position.
// GRAY_STEP_SYNC_EN adds a 2-flop synchronizer ahead of the capture register.
module gray_step_decoder
  import gray_step_pkg::*;
#(
  parameter int unsigned WIDTH = GS_WIDTH,
  parameter int unsigned POS_W = GS_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_valid,
  output logic             step_dir,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] D_UP = WIDTH'(DELTA_UP);
  localparam logic [WIDTH-1:0] D_DN = WIDTH'(DELTA_DN);

  logic [WIDTH-1:0] gray_src;

`ifdef GRAY_STEP_SYNC_EN
  localparam int unsigned VLD_N = 3;

  gray_step_sync #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d_i  (gray_in),
    .q_o  (gray_src)
  );
`else
  localparam int unsigned VLD_N = 1;

  assign gray_src = gray_in;
`endif

  logic [WIDTH-1:0] gray_q;
  logic [VLD_N-1:0] vld_q;
  gs_state_e        state_q;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] delta;
  logic             cap_vld;

  // Capture register plus a fill marker so reset zeros are never mistaken for a sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_q <= '0;
      vld_q  <= '0;
    end else begin
      gray_q <= gray_src;
      vld_q  <= VLD_N'({vld_q, 1'b1});
    end
  end

  assign cap_vld = vld_q[VLD_N-1];
  assign b_new   = WIDTH'(gray2bin(GS_MAX_W'(gray_q)));
  assign delta   = b_new - bin_out;

  // Tracker FSM; bin_out doubles as the previous accepted binary sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEED;
      bin_out    <= '0;
      step_valid <= 1'b0;
      step_dir   <= 1'b1;
      pos        <= '0;
      wrap       <= 1'b0;
      err        <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      wrap       <= 1'b0;
      if (err_clr) begin
        err     <= 1'b0;
        state_q <= SEED;
      end else if (cap_vld) begin
        case (state_q)
          SEED: begin
            bin_out <= b_new;
            state_q <= TRACK;
          end
          TRACK: begin
            if (delta == D_UP) begin
              step_valid <= 1'b1;
              step_dir   <= 1'b1;
              pos        <= pos + POS_W'(1);
              wrap       <= (pos == {POS_W{1'b1}});
              bin_out    <= b_new;
            end else if (delta == D_DN) begin
              step_valid <= 1'b1;
              step_dir   <= 1'b0;
              pos        <= pos - POS_W'(1);
              wrap       <= (pos == '0);
              bin_out    <= b_new;
            end else if (delta != '0) begin
              err     <= 1'b1;
              bin_out <= b_new;
              state_q <= FAULT;
            end
          end
          FAULT: begin
            bin_out <= b_new;
          end
          default: begin
            state_q <= SEED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder with hand-computed expectations.
module tb_gray_step_decoder;

`ifdef GRAY_STEP_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] gray_in;
  logic       err_clr;
  logic [2:0] bin_out;
  logic       step_valid;
  logic       step_dir;
  logic [7:0] pos;
  logic       wrap;
  logic       err;

  int total = 0;
  int bad   = 0;

  gray_step_decoder dut (
    .clk       (clk),
    .reset     (rst_n),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .pos       (pos),
    .wrap      (wrap),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  // Drive one sample and wait until the decoder has registered its reaction.
  task automatic apply(input logic [2:0] g);
    @(negedge clk);
    gray_in = g;
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  task automatic count_pulses(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step_valid) c++;
    end
  endtask

  int steps;
  int wraps;
  int pulses;

  initial begin
    rst_n   = 1'b0;
    gray_in = 3'b000;
    err_clr = 1'b0;
    #23;
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_sv", 32'(step_valid), 0);
    chk("rst_dir", 32'(step_dir), 1);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(4, pulses);
    chk("seed_nopulse", 32'(pulses), 0);
    chk("seed_pos", 32'(pos), 0);

    // Test 1: up steps, with exact latency check on the first one
    @(negedge clk);
    gray_in = 3'b001;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("lat_early_sv", 32'(step_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_sv", 32'(step_valid), 1);
    chk("t1_pos1", 32'(pos), 1);
    apply(3'b011);
    chk("t1_sv2", 32'(step_valid), 1);
    chk("t1_pos2", 32'(pos), 2);
    apply(3'b010);
    chk("t1_pos3", 32'(pos), 3);
    chk("t1_dir", 32'(step_dir), 1);
    chk("t1_bin", 32'(bin_out), 3);
    chk("t1_err", 32'(err), 0);

    // Test 2: down steps through 0 -> 255
    apply(3'b011);
    chk("t2_sv", 32'(step_valid), 1);
    chk("t2_dir", 32'(step_dir), 0);
    chk("t2_pos2", 32'(pos), 2);
    chk("t2_nowrap", 32'(wrap), 0);
    apply(3'b001);
    chk("t2_pos1", 32'(pos), 1);
    apply(3'b000);
    chk("t2_pos0", 32'(pos), 0);
    apply(3'b100);
    chk("t2_pos255", 32'(pos), 255);
    chk("t2_wrap", 32'(wrap), 1);
    chk("t2_bin", 32'(bin_out), 7);
    chk("t2_dir_dn", 32'(step_dir), 0);
    @(posedge clk);
    #1;
    chk("t2_wrap_clr", 32'(wrap), 0);
    chk("t2_sv_clr", 32'(step_valid), 0);

    // Test 3: up wrap 255 -> 0, then 255 more ups and another wrap
    apply(3'b000);
    chk("t3_pos0", 32'(pos), 0);
    chk("t3_wrap_a", 32'(wrap), 1);
    chk("t3_dir", 32'(step_dir), 1);
    steps = 0;
    wraps = 0;
    for (int i = 1; i <= 255; i++) begin
      apply(to_gray(i % 8));
      if (step_valid) steps++;
      if (wrap) wraps++;
    end
    chk("t3_steps", 32'(steps), 255);
    chk("t3_nowraps", 32'(wraps), 0);
    chk("t3_pos255", 32'(pos), 255);
    apply(to_gray(0));
    chk("t3_wrap_pos", 32'(pos), 0);
    chk("t3_wrap_b", 32'(wrap), 1);
    @(posedge clk);
    #1;
    chk("t3_wrap_clr", 32'(wrap), 0);

    // Test 4: illegal skip, fault behaviour, clear and re-seed
    apply(3'b001);
    chk("t4_pos1", 32'(pos), 1);
    apply(3'b110);
    chk("t4_err", 32'(err), 1);
    chk("t4_nosv", 32'(step_valid), 0);
    chk("t4_pos_frz", 32'(pos), 1);
    chk("t4_bin4", 32'(bin_out), 4);
    apply(3'b111);
    chk("t4_fault_nosv", 32'(step_valid), 0);
    chk("t4_fault_pos", 32'(pos), 1);
    chk("t4_fault_bin", 32'(bin_out), 5);
    chk("t4_err_held", 32'(err), 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_err_clr", 32'(err), 0);
    @(negedge clk);
    err_clr = 1'b0;
    count_pulses(3, pulses);
    chk("t4_reseed_nopulse", 32'(pulses), 0);
    chk("t4_reseed_bin", 32'(bin_out), 5);
    apply(3'b101);
    chk("t4_step_sv", 32'(step_valid), 1);
    chk("t4_step_pos", 32'(pos), 2);

    // Test 5: asynchronous reset with a step in flight
    apply(3'b100);
    apply(3'b000);
    apply(3'b001);
    chk("t5_pos5", 32'(pos), 5);
    @(negedge clk);
    gray_in = 3'b011;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pos", 32'(pos), 0);
    chk("t5_rst_bin", 32'(bin_out), 0);
    chk("t5_rst_dir", 32'(step_dir), 1);
    chk("t5_rst_sv", 32'(step_valid), 0);
    count_pulses(2, pulses);
    chk("t5_abort", 32'(pulses), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(5, pulses);
    chk("t5_seed_nopulse", 32'(pulses), 0);
    chk("t5_seed_pos", 32'(pos), 0);
    chk("t5_seed_bin", 32'(bin_out), 2);
    apply(3'b010);
    chk("t5_step_sv", 32'(step_valid), 1);
    chk("t5_step_pos", 32'(pos), 1);

    // Constant input must never produce steps
    count_pulses(20, pulses);
    chk("hold_nopulse", 32'(pulses), 0);
    chk("hold_pos", 32'(pos), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
